// File: rtl/pwm.sv
// Fixed-period PWM for one motor channel: period 2^W cycles, high for `duty` cycles.
// Define PWM_SYNC_UPDATE_EN to defer duty updates to the next period boundary.
module pwm #(
  parameter type RPM_TYPE = logic [6:0]
) (
  input  logic    clk,
  input  logic    resetn,
  input  logic    set,
  input  RPM_TYPE mot_rpm,
  output logic    mot_pwm
);

  localparam int unsigned W = $bits(RPM_TYPE);

  logic [W-1:0] r_duty;
  logic [W-1:0] r_count;
  logic         r_pwm;
  logic [W-1:0] w_rpm;
  logic [W-1:0] w_count_nxt;

  assign w_rpm       = mot_rpm;
  assign w_count_nxt = r_count + W'(1);
  assign mot_pwm     = r_pwm;

`ifdef PWM_SYNC_UPDATE_EN
  logic [W-1:0] r_shadow;
  logic         w_wrap;
  logic [W-1:0] w_next_duty;

  assign w_wrap      = (r_count == '1);
  // A set landing on the wrap edge is taken directly so it is not lost for a period.
  assign w_next_duty = set ? w_rpm : r_shadow;

  always_ff @(posedge clk) begin
    if (resetn) begin
      r_duty   <= '0;
      r_shadow <= '0;
      r_count  <= '0;
      r_pwm    <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (set) begin
        r_shadow <= w_rpm;
      end
      if (w_wrap) begin
        r_duty <= w_next_duty;
        r_pwm  <= (w_next_duty != '0);
      end else begin
        r_pwm  <= (w_count_nxt < r_duty);
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_duty  <= '0;
      r_count <= '0;
      r_pwm   <= 1'b0;
    end else if (set) begin
      r_duty  <= w_rpm;
      r_count <= '0;
      r_pwm   <= (w_rpm != '0);
    end else begin
      r_count <= w_count_nxt;
      r_pwm   <= (w_count_nxt < r_duty);
    end
  end
`endif

endmodule

// File: tb/tb_pwm.sv
// Self-checking bench for pwm (default build): per-cycle model comparison
// plus directed high-count and waveform-shape checks.
module tb_pwm;

  localparam int PERIOD = 128;

  logic       clk;
  logic       resetn;
  logic       set;
  logic [6:0] mot_rpm;
  logic       mot_pwm;

  int checks;
  int failures;

  pwm #(.RPM_TYPE(logic [6:0])) dut (
    .clk     (clk),
    .resetn  (resetn),
    .set     (set),
    .mot_rpm (mot_rpm),
    .mot_pwm (mot_pwm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: output is a function of cycles elapsed since the last load edge.
  int   cyc;
  int   m_load;
  int   m_duty;
  logic m_exp;
  logic m_valid;

  initial begin
    cyc     = 0;
    m_load  = 0;
    m_duty  = 0;
    m_exp   = 1'b0;
    m_valid = 1'b0;
  end

  always @(posedge clk) begin
    if (resetn) begin
      m_duty  <= 0;
      m_exp   <= 1'b0;
      m_valid <= 1'b1;
    end else if (set) begin
      m_duty  <= int'(mot_rpm);
      m_load  <= cyc;
      m_exp   <= (mot_rpm != 7'd0);
    end else begin
      m_exp   <= (m_duty != 0) && (((cyc - m_load) % PERIOD) < m_duty);
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (mot_pwm !== m_exp) begin
        failures++;
        $display("FAIL model_cycle%0d actual=%b expected=%b", cyc, mot_pwm, m_exp);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Leaves the bench at the negedge just after the set edge (cycle 1).
  task automatic pulse_set(input int rpm);
    mot_rpm = 7'(rpm);
    set     = 1'b1;
    @(negedge clk);
    set     = 1'b0;
  endtask

  task automatic count_highs(input int n, output int highs);
    highs = 0;
    for (int k = 0; k < n; k++) begin
      if (mot_pwm === 1'b1) highs++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
  endtask

  int   highs;
  int   lows;
  int   low_pos;
  logic wave [1:133];

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    set      = 1'b0;
    mot_rpm  = '0;
    @(negedge clk);

    // Reset sweep
    do_reset();
    chk("reset_pwm", int'(mot_pwm), 0);
    count_highs(256, highs);
    chk("reset_256_highs", highs, 0);

    // Full duty sweep
    for (int r = 0; r < PERIOD; r++) begin
      pulse_set(r);
      count_highs(PERIOD, highs);
      chk($sformatf("sweep_rpm%0d", r), highs, r);
    end

    // Waveform shape at duty 5
    pulse_set(5);
    for (int k = 1; k <= 133; k++) begin
      wave[k] = mot_pwm;
      @(negedge clk);
    end
    chk("shape_c1",   int'(wave[1]),   1);
    chk("shape_c5",   int'(wave[5]),   1);
    chk("shape_c6",   int'(wave[6]),   0);
    chk("shape_c128", int'(wave[128]), 0);
    chk("shape_c129", int'(wave[129]), 1);
    chk("shape_c133", int'(wave[133]), 1);
    highs = 0;
    for (int k = 1; k <= 133; k++) if (wave[k] === 1'b1) highs++;
    chk("shape_highs133", highs, 10);

    // Boundary 127: one low per period, at position 127 (cycle 128)
    pulse_set(127);
    lows = 0;
    low_pos = -1;
    for (int k = 1; k <= PERIOD; k++) begin
      if (mot_pwm === 1'b0) begin
        lows++;
        low_pos = k;
      end
      @(negedge clk);
    end
    chk("max_lows", lows, 1);
    chk("max_low_cycle", low_pos, 128);

    // Boundary 0
    pulse_set(0);
    count_highs(2 * PERIOD, highs);
    chk("zero_highs", highs, 0);

    // set held for several cycles with changing value, then mot_rpm changes while idle
    mot_rpm = 7'd3;
    set     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("hold_pwm%0d", k), int'(mot_pwm), 1);
      mot_rpm = 7'(20 + k);
    end
    set = 1'b0;
    // last captured value is 22 (held at cycle 1 of the window)
    mot_rpm = 7'd90;
    count_highs(PERIOD, highs);
    chk("hold_then_ignore_highs", highs, 22);

    // Reset and set on the same edge
    mot_rpm = 7'd64;
    set     = 1'b1;
    resetn  = 1'b1;
    @(negedge clk);
    set     = 1'b0;
    resetn  = 1'b0;
    chk("prio_pwm", int'(mot_pwm), 0);
    count_highs(130, highs);
    chk("prio_highs", highs, 0);

    // Mid-period reset at duty 100
    pulse_set(100);
    repeat (30) @(negedge clk);
    chk("mid_before", int'(mot_pwm), 1);
    do_reset();
    chk("mid_after", int'(mot_pwm), 0);
    count_highs(PERIOD, highs);
    chk("mid_after_highs", highs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm.md
Name: pwm

Overview:
- Fixed-period PWM generator for one drone motor channel.
- Loaded with a duty value, it produces a period of 2^W clock cycles, where W is the bit width of the RPM type.
- Within each period, mot_pwm is high for exactly mot_rpm cycles.
- Sits between the flight-control/motor-mixing logic and the motor driver pin.

Parameters:
- RPM_TYPE, default logic [6:0]: type parameter for the duty/speed value. W = $bits(RPM_TYPE); period = 2^W cycles (128 at default).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- resetn  input  1  synchronous active-high reset; sampled on the clk rising edge.
- set  input  1  load strobe; when high on a clk edge, capture mot_rpm.
- mot_rpm  input  W (RPM_TYPE)  requested duty, high cycles per period, 0..2^W-1.
- mot_pwm  output  1  PWM drive to motor, registered.

Behaviour:
Internal state:
- duty register, W bits.
- count register, W bits, free-running period counter.

Reset (resetn=1 at an edge):
- duty=0, count=0, mot_pwm=0.
- Reset has priority over set on the same edge.

Load (set=1, resetn=0 at an edge), default build:
- duty<=mot_rpm.
- count<=0, restarting the period.
- mot_pwm<=(mot_rpm!=0).

Otherwise, each edge:
- count<=count+1, wrapping from 2^W-1 to 0 modulo 2^W.
- mot_pwm<=((count+1) mod 2^W) < duty, unsigned compare.

Resulting waveform:
- mot_pwm is high for period positions 0..duty-1 and low for positions duty..2^W-1.
- Any window of 2^W consecutive cycles contains exactly duty high cycles.

Boundaries:
- duty=0: mot_pwm constantly 0.
- duty=2^W-1: exactly one low cycle per period, at position 2^W-1.
- set held high for several cycles: re-captures every cycle and keeps count at 0. mot_pwm stays (mot_rpm!=0) until set drops.
- mot_rpm changes while set=0: ignored.
- Reset mid-period: output low on the next cycle; duty is cleared, so a new set is required.

Latency:
- New duty is visible on mot_pwm in the cycle immediately after the set edge.
- No handshake; set is a single-cycle strobe.

Optional Feature:
Macro PWM_SYNC_UPDATE_EN:
- Defined:
  - set loads a shadow register only; count is not restarted.
  - The shadow value is copied into duty when count wraps from 2^W-1 to 0, giving glitch-free period-aligned updates.
  - mot_pwm for the new period uses the new duty from position 0.
  - Reset clears shadow and duty.
  - Latency to the new duty is up to 2^W cycles.
- Undefined: immediate load and counter restart as described in Behaviour.

Test Plan:
1. Reset sweep: assert resetn 1 cycle, release -> mot_pwm=0 for 256 cycles (duty 0).
2. Full duty sweep, default build:
   - For each mot_rpm 0..127, pulse set 1 cycle, then count mot_pwm highs over the next 128 cycles.
   - Count must equal mot_rpm, 128 cases, 0 failures.
3. Waveform shape: set with mot_rpm=5 -> mot_pwm high cycles 1-5 after the set edge, low 6-128, high again 129-133.
4. Boundaries:
   - mot_rpm=127 -> one low cycle per 128-cycle period.
   - mot_rpm=0 -> never high.
5. Priority and mid-run reset:
   - resetn=1 and set=1 on the same edge with mot_rpm=64 -> mot_pwm=0 thereafter.
   - Reset mid-period at duty=100 -> mot_pwm=0 the next cycle and stays 0.
6. PWM_SYNC_UPDATE_EN defined:
   - Running at duty=10, set mot_rpm=50 at count=20 -> remainder of the current period keeps duty 10.
   - From the next wrap, 50 high cycles per period.
